// File: rtl/fm7_key_scheduler.sv
// -----------------------------------------------------------------------------
// fm7_key_scheduler
//
// Purpose:
//   Takes translated keyboard events from the PS/2 scan translator and feeds
//   them, one code at a time, to the CPU-visible key latch (FD01 data and
//   FD00 bit 7 = P0).
//   - Make events carrying a non-zero FM-7 code are buffered in a small FIFO.
//   - The most recent repeatable key is tracked, and typematic repeats are
//     generated while that key is held.
//   - A presenter FSM shows each code, holds key_pending until the CPU
//     acknowledges the read, and then waits a short hold-off before
//     presenting the next code.
//
// Ports:
//   CLKSYS       in   system clock
//   RESETBn      in   synchronous active-low reset
//   ev_stb       in   one-cycle pulse, translated key event valid
//   ev_make      in   1 = make, 0 = break (qualified by ev_stb)
//   ev_scan[8:0] in   physical key identity {E0, code}
//   ev_code[8:0] in   FM-7 code {P0, kdata}; 9'h000 means no code
//   ev_rpt_ok    in   key is repeatable (qualified by ev_stb & ev_make)
//   repeat_en    in   typematic enable; low disarms repeat
//   cpu_ack      in   one-cycle pulse, CPU read of FD01 completed
//   ovf_clr      in   clears fifo_ovf
//   kdata[7:0]   out  presented key code (FD01)
//   p0           out  presented code bit 8 (FD00 bit 7)
//   key_pending  out  code presented and not yet acknowledged
//   fifo_level   out  number of buffered entries
//   fifo_ovf     out  sticky flag, set when a make event was dropped
// -----------------------------------------------------------------------------
module fm7_key_scheduler #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [23:0] DELAY_CYC  = 24'd500000,
  parameter logic [23:0] RATE_CYC   = 24'd100000,
  parameter int          GAP_CYC    = 16
) (
  input  logic                              CLKSYS,
  input  logic                              RESETBn,
  input  logic                              ev_stb,
  input  logic                              ev_make,
  input  logic [8:0]                        ev_scan,
  input  logic [8:0]                        ev_code,
  input  logic                              ev_rpt_ok,
  input  logic                              repeat_en,
  input  logic                              cpu_ack,
  input  logic                              ovf_clr,
  output logic [7:0]                        kdata,
  output logic                              p0,
  output logic                              key_pending,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              fifo_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  // FIFO storage and control
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [8:0]       head;
  logic             fifo_empty;
  logic             fifo_full;

  // Repeat tracker
  logic             armed;
  logic [23:0]      cnt;
  logic [8:0]       rpt_scan;
  logic [8:0]       rpt_code;
  logic             fire;

  // Push / pop decisions
  logic             ev_push;
  logic             rpt_push;
  logic             push_req;
  logic             push_ok;
  logic [8:0]       push_data;
  logic             pop;
  logic             ovf_set;

  // Presenter FSM
  state_t           state;
  state_t           state_nxt;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_nxt;
  logic [7:0]       kdata_nxt;
  logic             p0_nxt;
  logic             pend_nxt;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_level = level;

  // A real make always has priority. A repeat is only injected when nothing
  // else is queued or showing, so holding a key cannot flood the FIFO.
  assign ev_push   = ev_stb & ev_make & (ev_code != 9'h000);
  assign fire      = armed & repeat_en & (cnt == 24'd0);
  assign rpt_push  = fire & ~ev_stb & fifo_empty & ~key_pending;
  assign push_req  = ev_push | rpt_push;
  assign push_data = ev_push ? ev_code : rpt_code;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push_ok   = push_req & (~fifo_full | pop);
  assign ovf_set   = ev_push & fifo_full & ~pop;

  // ---- FIFO storage (data, no reset) ----
  always_ff @(posedge CLKSYS) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // ---- FIFO pointers, level and overflow flag ----
  always_ff @(posedge CLKSYS) begin
    if (!RESETBn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A fresh overflow wins over a clear in the same cycle.
      if (ovf_set) begin
        fifo_ovf <= 1'b1;
      end else if (ovf_clr) begin
        fifo_ovf <= 1'b0;
      end
    end
  end

  // ---- Repeat tracker: arm state and countdown ----
  always_ff @(posedge CLKSYS) begin
    if (!RESETBn) begin
      armed <= 1'b0;
      cnt   <= 24'd0;
    end else if (!repeat_en) begin
      armed <= 1'b0;
    end else begin
      // The countdown keeps running through unrelated events. A fire that
      // lands on an ev_stb cycle is dropped, but the reload still happens.
      if (armed) begin
        if (cnt == 24'd0) begin
          cnt <= RATE_CYC - 24'd1;
        end else begin
          cnt <= cnt - 24'd1;
        end
      end
      if (ev_stb) begin
        if (ev_make) begin
          if (ev_rpt_ok && (ev_code != 9'h000)) begin
            armed <= 1'b1;
            cnt   <= DELAY_CYC - 24'd1;
          end else begin
            armed <= 1'b0;
          end
        end else if (ev_scan == rpt_scan) begin
          armed <= 1'b0;
        end
      end
    end
  end

  // ---- Repeat tracker: identity of the held key (data, no reset) ----
  always_ff @(posedge CLKSYS) begin
    if (repeat_en && ev_stb && ev_make && ev_rpt_ok && (ev_code != 9'h000)) begin
      rpt_scan <= ev_scan;
      rpt_code <= ev_code;
    end
  end

  // ---- Presenter FSM: next state and outputs ----
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    kdata_nxt = kdata;
    p0_nxt    = p0;
    pend_nxt  = key_pending;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          kdata_nxt = head[7:0];
          p0_nxt    = head[8];
          pend_nxt  = 1'b1;
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (cpu_ack) begin
          pend_nxt  = 1'b0;
          gap_nxt   = GAP_W'(GAP_CYC - 1);
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap == '0) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- Presenter FSM: state register and presented latch ----
  always_ff @(posedge CLKSYS) begin
    if (!RESETBn) begin
      state       <= S_IDLE;
      gap         <= '0;
      kdata       <= 8'h00;
      p0          <= 1'b0;
      key_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      gap         <= gap_nxt;
      kdata       <= kdata_nxt;
      p0          <= p0_nxt;
      key_pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_fm7_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fm7_key_scheduler
//
// Directed bench for fm7_key_scheduler.
//   FIFO_DEPTH = 8, DELAY_CYC = 20, RATE_CYC = 5, GAP_CYC = 4.
// A table of single-cycle stimulus records is applied first. Each record has
// a number of idle cycles and the expected outputs that follow it. The table
// covers reset, queueing, gap spacing and overflow. Hand-written sequences
// then cover typematic repeat timing and how repeat interacts with other
// events.
// -----------------------------------------------------------------------------
module tb_fm7_key_scheduler;

  logic       CLKSYS = 1'b0;
  logic       RESETBn = 1'b0;
  logic       ev_stb = 1'b0;
  logic       ev_make = 1'b0;
  logic [8:0] ev_scan = 9'h000;
  logic [8:0] ev_code = 9'h000;
  logic       ev_rpt_ok = 1'b0;
  logic       repeat_en = 1'b1;
  logic       cpu_ack = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] kdata;
  logic       p0;
  logic       key_pending;
  logic [3:0] fifo_level;
  logic       fifo_ovf;

  int vectors = 0;
  int miscompares = 0;

  fm7_key_scheduler #(
    .FIFO_DEPTH (8),
    .DELAY_CYC  (24'd20),
    .RATE_CYC   (24'd5),
    .GAP_CYC    (4)
  ) dut (
    .CLKSYS      (CLKSYS),
    .RESETBn     (RESETBn),
    .ev_stb      (ev_stb),
    .ev_make     (ev_make),
    .ev_scan     (ev_scan),
    .ev_code     (ev_code),
    .ev_rpt_ok   (ev_rpt_ok),
    .repeat_en   (repeat_en),
    .cpu_ack     (cpu_ack),
    .ovf_clr     (ovf_clr),
    .kdata       (kdata),
    .p0          (p0),
    .key_pending (key_pending),
    .fifo_level  (fifo_level),
    .fifo_ovf    (fifo_ovf)
  );

  always #5 CLKSYS = ~CLKSYS;

  typedef struct {
    bit         rstn;
    bit         stb;
    bit         make;
    bit         ack;
    bit         clr;
    logic [8:0] scan;
    logic [8:0] code;
    int         wait_n;
    logic [7:0] kd;
    bit         ep0;
    bit         pend;
    logic [3:0] lvl;
    bit         ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rstn, bit stb, bit make, bit ack, bit clr,
                              logic [8:0] scan, logic [8:0] code, int wait_n,
                              logic [7:0] kd, bit ep0, bit pend,
                              logic [3:0] lvl, bit ovf);
    vec_t v;
    v.rstn = rstn; v.stb = stb; v.make = make; v.ack = ack; v.clr = clr;
    v.scan = scan; v.code = code; v.wait_n = wait_n;
    v.kd = kd; v.ep0 = ep0; v.pend = pend; v.lvl = lvl; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then return all pulses to idle 1 ns after the edge.
  task automatic drive(input bit rstn, stb, make, rpt, ack, clr,
                       input logic [8:0] scan, code);
    RESETBn   = rstn;
    ev_stb    = stb;
    ev_make   = make;
    ev_rpt_ok = rpt;
    cpu_ack   = ack;
    ovf_clr   = clr;
    ev_scan   = scan;
    ev_code   = code;
    @(posedge CLKSYS);
    #1;
    RESETBn   = 1'b1;
    ev_stb    = 1'b0;
    ev_make   = 1'b0;
    ev_rpt_ok = 1'b0;
    cpu_ack   = 1'b0;
    ovf_clr   = 1'b0;
    ev_scan   = 9'h000;
    ev_code   = 9'h000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLKSYS);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [7:0] ekd, input logic ep0,
                       input logic epend, input logic [3:0] elvl, input logic eovf);
    vectors++;
    if (kdata !== ekd || p0 !== ep0 || key_pending !== epend ||
        fifo_level !== elvl || fifo_ovf !== eovf) begin
      miscompares++;
      $display("FAIL %s: got kdata=%h p0=%b pend=%b level=%0d ovf=%b, want kdata=%h p0=%b pend=%b level=%0d ovf=%b",
               nm, kdata, p0, key_pending, fifo_level, fifo_ovf,
               ekd, ep0, epend, elvl, eovf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

  initial begin
    // rstn stb make ack clr scan code wait | kdata p0 pend level ovf
    // Reset held for two cycles, then a single make with one-cycle latency.
    add(0,0,0,0,0, 9'h000, 9'h000, 0,  8'h00,0,0,4'd0,0);
    add(0,0,0,0,0, 9'h000, 9'h000, 0,  8'h00,0,0,4'd0,0);
    add(1,1,1,0,0, 9'h01C, 9'h061, 0,  8'h00,0,0,4'd1,0);
    add(1,0,0,0,0, 9'h000, 9'h000, 0,  8'h61,0,1,4'd0,0);
    add(1,0,0,1,0, 9'h000, 9'h000, 0,  8'h61,0,0,4'd0,0);
    // Three makes queue up during the gap; each one is presented GAP_CYC+1 cycles after the ack.
    add(1,1,1,0,0, 9'h016, 9'h031, 0,  8'h61,0,0,4'd1,0);
    add(1,1,1,0,0, 9'h01E, 9'h032, 0,  8'h61,0,0,4'd2,0);
    add(1,1,1,0,0, 9'h026, 9'h101, 0,  8'h61,0,0,4'd3,0);
    add(1,0,0,0,0, 9'h000, 9'h000, 0,  8'h61,0,0,4'd3,0);
    add(1,0,0,0,0, 9'h000, 9'h000, 0,  8'h31,0,1,4'd2,0);
    add(1,0,0,1,0, 9'h000, 9'h000, 0,  8'h31,0,0,4'd2,0);
    add(1,0,0,0,0, 9'h000, 9'h000, 3,  8'h31,0,0,4'd2,0);
    add(1,0,0,0,0, 9'h000, 9'h000, 0,  8'h32,0,1,4'd1,0);
    add(1,0,0,1,0, 9'h000, 9'h000, 4,  8'h32,0,0,4'd1,0);
    add(1,0,0,0,0, 9'h000, 9'h000, 0,  8'h01,1,1,4'd0,0);
    add(1,0,0,1,0, 9'h000, 9'h000, 5,  8'h01,1,0,4'd0,0);
    // An ack outside PRESENT is ignored; the last code stays latched.
    add(1,0,0,1,0, 9'h000, 9'h000, 0,  8'h01,1,0,4'd0,0);
    // Ten makes with no ack: the first is presented, 8 are buffered, the last is dropped.
    add(1,1,1,0,0, 9'h041, 9'h041, 0,  8'h01,1,0,4'd1,0);
    add(1,1,1,0,0, 9'h042, 9'h042, 0,  8'h41,0,1,4'd1,0);
    for (int k = 0; k < 7; k++) begin
      add(1,1,1,0,0, 9'h043 + 9'(k), 9'h043 + 9'(k), 0, 8'h41,0,1,4'(k+2),0);
    end
    add(1,1,1,0,0, 9'h04A, 9'h04A, 0,  8'h41,0,1,4'd8,1);
    // A clear in the same cycle as a new overflow loses; a clear on its own works.
    add(1,1,1,0,1, 9'h04B, 9'h04B, 0,  8'h41,0,1,4'd8,1);
    add(1,0,0,0,1, 9'h000, 9'h000, 0,  8'h41,0,1,4'd8,0);
    // Push into a full FIFO on the same cycle as a pop is accepted.
    add(1,0,0,1,0, 9'h000, 9'h000, 0,  8'h41,0,0,4'd8,0);
    add(1,0,0,0,0, 9'h000, 9'h000, 3,  8'h41,0,0,4'd8,0);
    add(1,1,1,0,0, 9'h04C, 9'h04C, 0,  8'h42,0,1,4'd8,0);
    // Reset mid-PRESENT with entries queued, then an ack that must be ignored.
    add(0,0,0,1,0, 9'h000, 9'h000, 0,  8'h00,0,0,4'd0,0);
    add(1,0,0,1,0, 9'h000, 9'h000, 2,  8'h00,0,0,4'd0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rstn, vecs[i].stb, vecs[i].make, 1'b0, vecs[i].ack,
            vecs[i].clr, vecs[i].scan, vecs[i].code);
      idle(vecs[i].wait_n);
      check($sformatf("vec%0d", i), vecs[i].kd, vecs[i].ep0, vecs[i].pend,
            vecs[i].lvl, vecs[i].ovf);
    end

    // Typematic repeat: make at edge N, first repeat fires at N+20, then every 5 cycles.
    drive(1,1,1,1,0,0, 9'h01C, 9'h061);                    // N
    check("t4_make_push", 8'h00,0,0,4'd1,0);
    drive(1,0,0,0,0,0, 9'h000, 9'h000);                    // N+1
    check("t4_present", 8'h61,0,1,4'd0,0);
    drive(1,0,0,0,1,0, 9'h000, 9'h000);                    // N+2 ack
    idle(17);                                              // N+19
    check("t4_before_delay", 8'h61,0,0,4'd0,0);
    idle(1);                                               // N+20 first fire
    check("t4_first_fire", 8'h61,0,0,4'd1,0);
    idle(1);                                               // N+21
    check("t4_first_present", 8'h61,0,1,4'd0,0);
    drive(1,0,0,0,1,0, 9'h000, 9'h000);                    // N+22 ack
    idle(4);                                               // N+26, fire at N+25
    check("t4_rate_fire", 8'h61,0,0,4'd1,0);
    idle(1);                                               // N+27
    check("t4_rate_present", 8'h61,0,1,4'd0,0);
    idle(4);                                               // N+31, fire at N+30 skipped
    check("t4_no_flood", 8'h61,0,1,4'd0,0);
    drive(1,0,0,0,1,0, 9'h000, 9'h000);                    // N+32 ack
    idle(3);                                               // N+35 fire during gap
    check("t4_fire_in_gap", 8'h61,0,0,4'd1,0);
    idle(2);                                               // N+37
    check("t4_gap_present", 8'h61,0,1,4'd0,0);
    drive(1,0,0,0,1,0, 9'h000, 9'h000);                    // N+38 ack
    drive(1,1,0,0,0,0, 9'h01C, 9'h061);                    // N+39 break of held key
    idle(25);
    check("t4_break_stops", 8'h61,0,0,4'd0,0);

    // Repeat interplay: a break of another key keeps repeat; a non-repeatable make disarms.
    drive(1,1,1,1,0,0, 9'h01C, 9'h061);                    // P
    drive(1,0,0,0,0,0, 9'h000, 9'h000);                    // P+1
    check("t5_present", 8'h61,0,1,4'd0,0);
    drive(1,0,0,0,1,0, 9'h000, 9'h000);                    // P+2 ack
    drive(1,1,0,0,0,0, 9'h012, 9'h000);                    // P+3 break, other key
    idle(16);                                              // P+19
    check("t5_before_fire", 8'h61,0,0,4'd0,0);
    idle(1);                                               // P+20
    check("t5_other_break_kept", 8'h61,0,0,4'd1,0);
    idle(1);                                               // P+21
    check("t5_repeat_present", 8'h61,0,1,4'd0,0);
    drive(1,0,0,0,1,0, 9'h000, 9'h000);                    // P+22 ack
    drive(1,1,1,0,0,0, 9'h014, 9'h000);                    // P+23 non-rpt make, no code
    idle(30);
    check("t5_nonrpt_disarm", 8'h61,0,0,4'd0,0);

    // Dropping repeat_en disarms, and repeat stays off after it is raised again.
    drive(1,1,1,1,0,0, 9'h01C, 9'h061);
    drive(1,0,0,0,0,0, 9'h000, 9'h000);
    drive(1,0,0,0,1,0, 9'h000, 9'h000);
    repeat_en = 1'b0;
    idle(30);
    check("t7_repeat_en_low", 8'h61,0,0,4'd0,0);
    repeat_en = 1'b1;
    idle(30);
    check("t7_stays_disarmed", 8'h61,0,0,4'd0,0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
